// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the CPU's single-port program/data memory: the CPU has
// fixed priority, the debug port has a starvation guard and a lock mode for bursts.
module mem_port_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_memrq,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_wait,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_rnw,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, state_next;
  logic [3:0] starve_cnt;
  logic       cpu_grant, dbg_grant;
  logic       locked;

  // A lock only holds while dbg_lock stays high; a LOCK cycle with dbg_lock=0
  // is arbitrated exactly like ARB.
  assign locked = (state == LOCK) && dbg_lock;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    if (!rst) begin
      if (locked) begin
        dbg_grant = dbg_req;
      end else if (cpu_memrq && dbg_req) begin
        if (starve_cnt == MAX_WAIT_C) dbg_grant = 1'b1;
        else                          cpu_grant = 1'b1;
      end else begin
        cpu_grant = cpu_memrq;
        dbg_grant = dbg_req;
      end
    end
  end

  always_comb begin
    state_next = ARB;
    if ((dbg_grant && dbg_lock) || locked) state_next = LOCK;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_grant) begin
      mem_en    = 1'b1;
      mem_we    = ~cpu_rnw;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_en    = 1'b1;
      mem_we    = ~dbg_rnw;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      state      <= state_next;
      cpu_rvalid <= cpu_grant & cpu_rnw;
      dbg_rvalid <= dbg_grant & dbg_rnw;
      if (!dbg_req || dbg_grant)      starve_cnt <= '0;
      else if (starve_cnt != MAX_WAIT_C) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign cpu_wait  = cpu_memrq & ~cpu_grant;
  assign dbg_gnt   = dbg_grant;
  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory behind it;
// inputs change 1 ns after the rising edge and outputs are sampled 1 ns later.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_memrq, cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_wait, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req, dbg_rnw, dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_memrq  (cpu_memrq),
    .cpu_rnw    (cpu_rnw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wait   (cpu_wait),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_req    (dbg_req),
    .dbg_rnw    (dbg_rnw),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_lock   (dbg_lock),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port memory; reset preloads the word read by the first test.
  always @(posedge clk) begin
    if (rst) begin
      mem[12'h010] <= 16'h2345;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic rnw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
    cpu_memrq = req;
    cpu_rnw   = rnw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic rnw, input logic lock,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    dbg_req   = req;
    dbg_rnw   = rnw;
    dbg_lock  = lock;
    dbg_addr  = addr;
    dbg_wdata = wdata;
  endtask

  initial begin
    logic exp_dbg;
    logic prev_cpu;

    // Reset with both masters requesting: nothing granted, CPU told to wait.
    rst = 1'b1;
    drive_cpu(1'b1, 1'b1, 12'h010, 16'h0000);
    drive_dbg(1'b1, 1'b1, 1'b0, 12'h020, 16'h0000);
    tick();
    tick();
    check("rst_cpu_wait",   cpu_wait,   1);
    check("rst_dbg_gnt",    dbg_gnt,    0);
    check("rst_mem_en",     mem_en,     0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_dbg_rvalid", dbg_rvalid, 0);

    rst = 1'b0;
    drive_cpu(1'b0, 1'b1, 12'h000, 16'h0000);
    drive_dbg(1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
    tick();

    // Isolated CPU read of 0x010.
    drive_cpu(1'b1, 1'b1, 12'h010, 16'h0000);
    #1;
    check("cpu_rd_mem_en",   mem_en,   1);
    check("cpu_rd_mem_we",   mem_we,   0);
    check("cpu_rd_mem_addr", mem_addr, 12'h010);
    check("cpu_rd_wait",     cpu_wait, 0);
    tick();

    // Isolated debug write of 0x7ABC to 0x020; read data from the CPU read shows up.
    drive_cpu(1'b0, 1'b1, 12'h000, 16'h0000);
    drive_dbg(1'b1, 1'b0, 1'b0, 12'h020, 16'h7ABC);
    #1;
    check("cpu_rd_rvalid",    cpu_rvalid, 1);
    check("cpu_rd_rdata",     cpu_rdata,  16'h2345);
    check("dbg_wr_gnt",       dbg_gnt,    1);
    check("dbg_wr_mem_we",    mem_we,     1);
    check("dbg_wr_mem_addr",  mem_addr,   12'h020);
    check("dbg_wr_mem_wdata", mem_wdata,  16'h7ABC);
    tick();

    drive_dbg(1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
    #1;
    check("dbg_wr_no_rvalid", dbg_rvalid, 0);
    check("cpu_rvalid_once",  cpu_rvalid, 0);
    tick();

    // Contention, both reading continuously: C,C,C,D,C,C,C,D.
    prev_cpu = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_cpu(1'b1, 1'b1, 12'h030, 16'h0000);
      drive_dbg(1'b1, 1'b1, 1'b0, 12'h040, 16'h0000);
      exp_dbg = (i == 3) || (i == 7);
      #1;
      check($sformatf("cont_dbg_gnt_%0d", i),  dbg_gnt,  exp_dbg);
      check($sformatf("cont_cpu_wait_%0d", i), cpu_wait, exp_dbg);
      if (i > 0) check($sformatf("cont_cpu_rvalid_%0d", i), cpu_rvalid, prev_cpu);
      prev_cpu = ~exp_dbg;
      tick();
    end
    drive_cpu(1'b0, 1'b1, 12'h000, 16'h0000);
    drive_dbg(1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
    #1;
    check("cont_end_cpu_rvalid", cpu_rvalid, 0);
    check("cont_end_dbg_rvalid", dbg_rvalid, 1);
    tick();

    // Lock burst: debug writes 0x000..0x003, CPU starts competing after the first.
    for (int i = 0; i < 4; i++) begin
      drive_dbg(1'b1, 1'b0, 1'b1, 12'(i), 16'(16'hA000 + i));
      drive_cpu(i > 0, 1'b0, 12'h050, 16'h1111);
      #1;
      check($sformatf("lock_dbg_gnt_%0d", i),  dbg_gnt,  1);
      check($sformatf("lock_mem_addr_%0d", i), mem_addr, i);
      if (i > 0) check($sformatf("lock_cpu_wait_%0d", i), cpu_wait, 1);
      tick();
    end
    // Idle debug cycle inside LOCK still blocks the CPU.
    drive_dbg(1'b0, 1'b0, 1'b1, 12'h000, 16'h0000);
    #1;
    check("lock_idle_cpu_wait", cpu_wait, 1);
    check("lock_idle_mem_en",   mem_en,   0);
    tick();
    // Lock released, no competition: CPU write goes through.
    drive_dbg(1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    #1;
    check("unlock_cpu_wait", cpu_wait,  0);
    check("unlock_mem_we",   mem_we,    1);
    check("unlock_mem_addr", mem_addr,  12'h050);
    check("unlock_wdata",    mem_wdata, 16'h1111);
    tick();

    // Lock release colliding with a CPU request while starve_cnt is 0.
    drive_cpu(1'b0, 1'b1, 12'h060, 16'h0000);
    drive_dbg(1'b1, 1'b0, 1'b1, 12'h004, 16'h0004);
    #1;
    check("rel_enter_gnt", dbg_gnt, 1);
    tick();
    drive_cpu(1'b1, 1'b1, 12'h060, 16'h0000);
    drive_dbg(1'b1, 1'b0, 1'b0, 12'h005, 16'h0005);
    #1;
    check("rel_cpu_wait", cpu_wait, 0);
    check("rel_dbg_gnt",  dbg_gnt,  0);
    check("rel_mem_addr", mem_addr, 12'h060);
    tick();
    // Back in ARB: dbg_lock without a debug request does not block the CPU.
    drive_dbg(1'b0, 1'b0, 1'b1, 12'h000, 16'h0000);
    #1;
    check("rel_arb_cpu_wait", cpu_wait, 0);
    tick();

    // Reset while LOCKed with a debug read in flight.
    drive_cpu(1'b0, 1'b1, 12'h000, 16'h0000);
    drive_dbg(1'b1, 1'b1, 1'b1, 12'h020, 16'h0000);
    #1;
    check("rstl_dbg_gnt", dbg_gnt, 1);
    tick();
    rst = 1'b1;
    drive_cpu(1'b1, 1'b1, 12'h070, 16'h0000);
    #1;
    check("rstl_rvalid_pre", dbg_rvalid, 1);
    check("rstl_rdata",      dbg_rdata,  16'h7ABC);
    check("rstl_dbg_gnt0",   dbg_gnt,    0);
    check("rstl_mem_en",     mem_en,     0);
    check("rstl_cpu_wait",   cpu_wait,   1);
    tick();
    rst = 1'b0;
    drive_dbg(1'b0, 1'b1, 1'b1, 12'h000, 16'h0000);
    #1;
    check("rstl_rvalid_drop", dbg_rvalid, 0);
    check("rstl_cpu_wait0",   cpu_wait,   0);
    check("rstl_mem_en1",     mem_en,     1);
    check("rstl_mem_addr",    mem_addr,   12'h070);
    tick();

    // Write-then-read of the same address by different masters.
    drive_cpu(1'b1, 1'b0, 12'h100, 16'h0055);
    drive_dbg(1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
    #1;
    check("wtr_cpu_we", mem_we, 1);
    tick();
    drive_cpu(1'b0, 1'b1, 12'h000, 16'h0000);
    drive_dbg(1'b1, 1'b1, 1'b0, 12'h100, 16'h0000);
    #1;
    check("wtr_dbg_gnt", dbg_gnt, 1);
    tick();
    drive_dbg(1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
    #1;
    check("wtr_dbg_rvalid", dbg_rvalid, 1);
    check("wtr_dbg_rdata",  dbg_rdata,  16'h0055);
    check("wtr_cpu_rvalid", cpu_rvalid, 0);
    tick();

    // CPU stopped: every debug request is granted.
    for (int i = 0; i < 5; i++) begin
      drive_dbg(1'b1, 1'b1, 1'b0, 12'(12'h200 + i), 16'h0000);
      #1;
      check($sformatf("stop_dbg_gnt_%0d", i), dbg_gnt, 1);
      tick();
    end
    drive_dbg(1'b0, 1'b1, 1'b0, 12'h000, 16'h0000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
